// File: rtl/player_action_encoder.sv
// Per-player button front end: latches presses between game ticks and emits one action code per tick.
// Latency: result visible the cycle after the tick edge; no backpressure, the tick cadence is fixed.
module player_action_encoder #(
  parameter int TICK_DIV = 4,
  parameter int COOLDOWN = 2,
  parameter int MIRROR   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] btn,
  output logic [2:0] action,
  output logic       action_valid,
  output logic [2:0] state,
  output logic       busy
);
  localparam logic [2:0] ACT_KICK   = 3'b000;
  localparam logic [2:0] ACT_PUNCH  = 3'b001;
  localparam logic [2:0] ACT_AWAIT  = 3'b010;
  localparam logic [2:0] ACT_JUMP   = 3'b011;
  localparam logic [2:0] ACT_LEFT1  = 3'b100;
  localparam logic [2:0] ACT_LEFT2  = 3'b101;
  localparam logic [2:0] ACT_RIGHT1 = 3'b110;
  localparam logic [2:0] ACT_RIGHT2 = 3'b111;
  localparam logic [2:0] POS_RESET  = (MIRROR != 0) ? 3'b001 : 3'b100;
  localparam logic [7:0] TICK_LAST  = 8'(TICK_DIV - 1);
  localparam logic [2:0] CD_LOAD    = 3'(COOLDOWN);

  logic [7:0] tick_cnt;
  logic [4:0] btn_q;
  logic [4:0] pending;
  logic [2:0] cd_cnt;
  logic       tick;
  logic [4:0] rise;
  logic [4:0] cand;
  logic       attack_ok;
  logic       prev_left;
  logic       prev_right;
  logic       left_ok;
  logic       right_ok;
  logic [2:0] next_action;
  logic [2:0] next_state;
  logic [2:0] next_cd;

  assign tick       = (tick_cnt == TICK_LAST);
  assign rise       = btn & ~btn_q;
  assign cand       = pending | rise;
  assign attack_ok  = (cd_cnt == 3'd0);
  assign prev_left  = (action == ACT_LEFT1) || (action == ACT_LEFT2);
  assign prev_right = (action == ACT_RIGHT1) || (action == ACT_RIGHT2);
  // A held direction keeps moving on later ticks even without a fresh rise.
  assign left_ok    = cand[1] | (btn[1] & prev_left);
  assign right_ok   = cand[0] | (btn[0] & prev_right);

  always_comb begin
    next_action = ACT_AWAIT;
    next_state  = state;
    next_cd     = (cd_cnt != 3'd0) ? cd_cnt - 3'd1 : 3'd0;
    if (cand[4] && attack_ok) begin
      next_action = ACT_KICK;
      next_cd     = CD_LOAD;
    end else if (cand[3] && attack_ok) begin
      next_action = ACT_PUNCH;
      next_cd     = CD_LOAD;
    end else if (cand[2]) begin
      next_action = ACT_JUMP;
    end else if (left_ok) begin
      next_action = (prev_left && btn[1]) ? ACT_LEFT2 : ACT_LEFT1;
      next_state  = state[2] ? state : {state[1:0], 1'b0};
    end else if (right_ok) begin
      next_action = (prev_right && btn[0]) ? ACT_RIGHT2 : ACT_RIGHT1;
      next_state  = state[0] ? state : {1'b0, state[2:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt     <= 8'd0;
      btn_q        <= 5'd0;
      pending      <= 5'd0;
      cd_cnt       <= 3'd0;
      action       <= ACT_AWAIT;
      action_valid <= 1'b0;
      state        <= POS_RESET;
      busy         <= 1'b0;
    end else begin
      btn_q        <= btn;
      action_valid <= tick;
      if (tick) begin
        tick_cnt <= 8'd0;
        pending  <= 5'd0;
        action   <= next_action;
        state    <= next_state;
        cd_cnt   <= next_cd;
        busy     <= (next_cd != 3'd0);
      end else begin
        tick_cnt <= tick_cnt + 8'd1;
        pending  <= pending | rise;
      end
    end
  end
endmodule

// File: doc/player_action_encoder.md
# player_action_encoder

Per-player input front end that converts raw button levels into the 3-bit game action code consumed by the player health/position logic. It runs a game-tick divider and latches button presses between ticks. At each tick it emits exactly one action from the fixed action alphabet, tracks its own player's one-hot position, and enforces an attack cooldown. One instance per player; its `action` and `state` outputs feed the opponent's action and state inputs, and its own player's health logic.

## Interface
- `TICK_DIV`, default 4: clk cycles per game tick; legal range 2..255.
- `COOLDOWN`, default 2: ticks after a kick or punch during which further attacks are refused; legal range 0..7.
- `MIRROR`, default 0: position reset value. 0 = left-edge player, reset 3'b100. 1 = right-edge player, reset 3'b001.
- `clk`  in  1  system clock; single clock domain, all state on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn`  in  5  synchronous button levels {kick, punch, jump, left, right} = bits [4:0]; already synchronized and debounced upstream.
- `action`  out  3  encoded action: kick 000, punch 001, await 010, jump 011, left1 100, left2 101, right1 110, right2 111.
- `action_valid`  out  1  one-cycle pulse on the cycle `action`/`state` are updated.
- `state`  out  3  one-hot physical position; bit2 = leftmost, bit0 = rightmost.
- `busy`  out  1  high while the attack cooldown counter is nonzero.

## Operation
- Reset values: `action` = 010 (await), `action_valid` = 0, `state` = 100 if MIRROR=0 else 001, `busy` = 0. Tick counter, cooldown counter, pending bits and `btn_q` all reset to 0.
- Edge detect: `btn_q` <= `btn` every cycle. A rise is `btn & ~btn_q`. Pending bits are sticky: they are set by a rise and cleared only on a tick edge.
- Tick: the counter runs 0..TICK_DIV-1 and wraps. A tick edge is the posedge at which count == TICK_DIV-1.
- Decision at the tick edge uses `cand` = pending | rise (rises in the tick cycle itself are included).
- Priority, highest first:
  - kick
  - punch
  - jump
  - left
  - right
  - no candidate: await
- Cooldown: if the cooldown counter != 0, kick and punch candidates are discarded and priority falls through to the next candidate.
- Movement qualification: left qualifies if `cand[1]` is set, or `btn[1]` is high and the previous action was left1/left2. Right qualifies by the same rule using bit 0 and right1/right2.
- Movement code: a qualified move whose previous action was the same direction and whose button is still held emits the dash code (left2/right2). Otherwise it emits left1/right1.
- Position update:
  - left/left2: `state` <= `state` << 1, saturating at 100.
  - right/right2: `state` <= `state` >> 1, saturating at 001.
  - The action code is still emitted when saturated.
  - kick, punch, jump and await leave `state` unchanged.
- Cooldown counter:
  - Issuing kick/punch loads COOLDOWN.
  - Otherwise the counter decrements by 1 at each tick edge while nonzero.
  - Load takes precedence over decrement.
  - COOLDOWN = 0 disables the cooldown; `busy` stays 0.
- All pending bits clear at every tick edge, including discarded attacks.

## Timing
- Latency: a press whose rise occurs at any edge up to and including a tick edge is acted on at that tick edge. `action` and `state` are visible the following cycle with `action_valid` = 1.
- `action_valid` is high exactly 1 cycle per TICK_DIV cycles. `action` and `state` hold between pulses.
- The first pulse after reset release is at the TICK_DIV-th posedge.
- Several buttons rising in one tick window: only the highest-priority qualified candidate is emitted; the others are dropped.
- Reset mid-tick clears pending presses and any in-progress cooldown immediately (asynchronous).
- `busy` is registered alongside the cooldown counter. It rises the cycle after a kick/punch tick edge and falls the cycle after the tick edge that decrements the counter to 0.

## Test plan
All scenarios use TICK_DIV=4, COOLDOWN=2, MIRROR=0 unless stated.

- Reset, no buttons: check the reset values, then `action_valid` pulses every 4 cycles with `action`=010 and `state`=100.
- Press right, release within one tick window, then repeat once: `action`=110 and `state`=010 on the first pulse; `action`=110 and `state`=001 on the second pulse.
- Hold right across 3 ticks from `state`=100: `action` sequence 110, 111, 111; `state` sequence 010, 001, 001 (saturated).
- Press kick at tick 0, then kick again in each of the next two tick windows: `action` sequence 000, 010, 010. `busy`=1 for 2 ticks. A third kick press after `busy` falls yields 000.
- Kick, punch and left all rise in the same cycle: emits 000 only and `state` is unchanged. The next tick, with no new presses, emits 010.
- MIRROR=1: reset `state`=001; one left press gives `action`=100, `state`=010. Asserting `rst_n`=0 mid-window, with a punch pending, yields await on the first post-reset pulse.
